// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the instruction-memory address and read
// enable, captures the returned word into the IF/ID register, and handles
// stall, branch redirect with flush, and halt-opcode detection.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | core not running; pc held, IF/ID marked invalid, no memory read
// RUN   | fetching one word per edge unless stalled or redirected
// HALT  | HLT word issued; everything frozen until reset
module fetch_unit #(
    parameter int                      PC_WIDTH    = 6,
    parameter int                      INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
    parameter logic [3:0]              HALT_OPCODE = 4'hF,
    parameter logic [INSTR_WIDTH-1:0]  NOP_WORD    = '0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   stall_i,
    input  logic                   branch_taken_i,
    input  logic [PC_WIDTH-1:0]    branch_target_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic                   mem_enable_o,
    output logic [INSTR_WIDTH-1:0] ir_out_o,
    output logic [PC_WIDTH-1:0]    ir_pc_o,
    output logic                   ir_valid_o,
    output logic                   halted_o,
    output logic [7:0]             fetch_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE    = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]          COUNT_MAX = 8'hFF;

    state_t                   state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
    logic [PC_WIDTH-1:0]      ir_pc_q, ir_pc_d;
    logic                     ir_valid_q, ir_valid_d;
    logic                     halted_q, halted_d;
    logic [7:0]               count_q, count_d;

    logic                     is_halt_word;
    logic [7:0]               count_inc;

    // Opcode decode of the word currently on the memory read bus.
    always_comb begin
        is_halt_word = (instr_i[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
        count_inc    = (count_q == COUNT_MAX) ? COUNT_MAX : (count_q + 8'd1);
    end

    // State register and datapath registers; reset aborts any state at once.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= NOP_WORD;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    // Next-state and next-datapath logic; everything holds unless changed.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        count_d    = count_q;

        unique case (state_q)
            IDLE: begin
                // The IDLE->RUN edge only arms the stage; the first fetch
                // happens on the following edge.
                ir_valid_d = 1'b0;
                if (enable_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d    = IDLE;
                    ir_valid_d = 1'b0;
                end else if (branch_taken_i) begin
                    // Redirect wins over stall: the wrong-path slot is flushed.
                    pc_d       = branch_target_i;
                    ir_d       = NOP_WORD;
                    ir_valid_d = 1'b0;
                end else if (stall_i) begin
                    // Hold everything for the downstream hazard.
                end else begin
                    ir_d       = instr_i;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    count_d    = count_inc;
                    if (is_halt_word) begin
                        // HLT is issued like any instruction but pc stays on it.
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            HALT: begin
                ir_valid_d = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                ir_valid_d = 1'b0;
            end
        endcase
    end

    // Memory read only while actively running.
    always_comb begin
        mem_enable_o = enable_i && (state_q == RUN);
    end

    assign pc_o          = pc_q;
    assign ir_out_o      = ir_q;
    assign ir_pc_o       = ir_pc_q;
    assign ir_valid_o    = ir_valid_q;
    assign halted_o      = halted_q;
    assign fetch_count_o = count_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 8-bit core. Sits directly upstream of the instruction memory and drives its 6-bit word address and read enable.
- Latches the returned 16-bit instruction into an IF/ID register with a valid flag, for the decoder downstream.
- Handles sequential PC increment, pipeline stall, branch redirect with flush, and halt-opcode detection.

Parameters:
- PC_WIDTH, 6, width of program counter / instruction memory address (64 words)
- INSTR_WIDTH, 16, instruction width
- RESET_PC, 6'd0, PC value loaded on reset
- HALT_OPCODE, 4'hF, value of instr[15:12] that denotes HLT
- NOP_WORD, 16'h0000, value placed in ir_out on reset/flush

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  core run enable; low holds the fetch stage idle
- stall  input  1  downstream hazard stall; hold PC and IF/ID register
- branch_taken  input  1  redirect request from execute stage
- branch_target  input  PC_WIDTH  redirect address
- instr_in  input  INSTR_WIDTH  combinational read data from instruction memory at address pc
- pc  output  PC_WIDTH  address to instruction memory
- mem_enable  output  1  read enable to instruction memory
- ir_out  output  INSTR_WIDTH  IF/ID instruction register
- ir_pc  output  PC_WIDTH  address ir_out was fetched from
- ir_valid  output  1  ir_out holds a real instruction for decode
- halted  output  1  HLT fetched; stage frozen
- fetch_count  output  8  count of instructions issued (ir_valid set by a fetch), saturates at 255

Behaviour:
- Reset (sync, highest priority): pc=RESET_PC, ir_out=NOP_WORD, ir_pc=0, ir_valid=0, halted=0, fetch_count=0, state=IDLE. Reset mid-operation aborts the current state immediately at that edge.
- mem_enable = enable && state==RUN (combinational). Instruction memory read is combinational, so instr_in is valid in the same cycle pc is presented.
- States: IDLE, RUN, HALT.
- IDLE:
  - pc held, ir_valid=0.
  - enable=1 moves to RUN next edge. No fetch occurs on that edge.
  - branch_taken and stall are ignored.
- RUN, priority order per edge:
  - enable=0: go to IDLE, ir_valid<=0, pc held.
  - branch_taken=1 (overrides stall): pc<=branch_target, ir_out<=NOP_WORD, ir_valid<=0 (flush), fetch_count unchanged.
  - stall=1: pc, ir_out, ir_pc, ir_valid, fetch_count all held.
  - otherwise fetch: ir_out<=instr_in, ir_pc<=pc, ir_valid<=1, fetch_count<=sat(fetch_count+1). pc<=pc+1 modulo 2^PC_WIDTH, so 63 wraps to 0.
  - Fetch where instr_in[15:12]==HALT_OPCODE: the HLT word is latched and issued (ir_valid=1, counted), pc is NOT incremented, state<=HALT, halted<=1.
- HALT:
  - ir_valid<=0 on the first HALT edge and stays 0.
  - pc, ir_out, ir_pc, fetch_count frozen. mem_enable=0.
  - enable, stall and branch_taken are ignored. Exit only via reset.
- Latency: instruction at address A appears on ir_out one edge after pc==A with no stall or branch.
- fetch_count saturates: at 255 a further fetch leaves it at 255.

Test Plan:
- Reset, enable=1, memory words 0..3 = 16'h1001, 16'h2002, 16'h3003, 16'h4004 -> after IDLE->RUN edge, ir_out follows 1001, 2002, 3003, 4004 on successive edges. ir_pc=0..3, ir_valid=1, fetch_count=4.
- Stall for 3 cycles while pc=2 -> pc stays 2, ir_out stays 16'h2002, fetch_count unchanged. After release, the next edge gives ir_out=16'h3003.
- branch_taken=1, branch_target=6'd40, with stall=1 in the same cycle -> next edge pc=40, ir_out=16'h0000, ir_valid=0. The following edge gives ir_out=mem[40], ir_pc=40.
- Start pc=63 via branch, mem[63]=16'h5555, mem[0]=16'h1001 -> ir_pc=63 then pc wraps to 0, next ir_out=16'h1001.
- mem[5]=16'hF000 -> ir_out=F000 with ir_valid=1 for one cycle, then halted=1, ir_valid=0, pc=5 frozen. branch_taken is ignored. reset returns pc=0, halted=0.
- Pulse enable low mid-run at pc=3 -> ir_valid=0 and pc held at 3. Re-enable -> IDLE->RUN, then fetch resumes at 3.
